// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational NOT/SHR ALU between two requesters.
// Accept -> one ISSUE cycle -> result held on the response channel until taken.
module alu_share_arbiter #(
   parameter int W = 7
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic         req0_op,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   input  logic         req1_op,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic         alu_op,
   input  logic [W-1:0] alu_y,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic [W-1:0] resp_data,
   output logic         resp_id,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t state;
   logic   last_grant;
   logic   cap_id;
   logic   grant0;
   logic   grant1;

   // On a tie the requester that did not win last time goes first.
   always_comb begin
      grant0 = req0_valid & (~req1_valid | last_grant);
      grant1 = req1_valid & (~req0_valid | ~last_grant);
   end

   assign req0_ready = (state == IDLE) & grant0;
   assign req1_ready = (state == IDLE) & grant1;

   // The ALU operand registers double as the capture registers: loaded on
   // accept, presented for the single ISSUE cycle, then cleared.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         cap_id     <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= 1'b0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_id    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant0 | grant1) begin
                  cap_id     <= grant1;
                  last_grant <= grant1;
                  alu_a      <= grant1 ? req1_a  : req0_a;
                  alu_b      <= grant1 ? req1_b  : req0_b;
                  alu_op     <= grant1 ? req1_op : req0_op;
                  busy       <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               resp_data  <= alu_y;
               resp_id    <= cap_id;
               resp_valid <= 1'b1;
               alu_a      <= '0;
               alu_b      <= '0;
               alu_op     <= 1'b0;
               state      <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               alu_a      <= '0;
               alu_b      <= '0;
               alu_op     <= 1'b0;
               resp_valid <= 1'b0;
               busy       <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: transaction-level round-robin model plus an external ALU model.
module tb_alu_share_arbiter;
   localparam int W = 7;

   logic         clk = 1'b0;
   logic         reset;
   logic         req0_valid, req0_ready, req0_op;
   logic [W-1:0] req0_a, req0_b;
   logic         req1_valid, req1_ready, req1_op;
   logic [W-1:0] req1_a, req1_b;
   logic [W-1:0] alu_a, alu_b, alu_y;
   logic         alu_op;
   logic         resp_valid, resp_ready, resp_id, busy;
   logic [W-1:0] resp_data;

   int checks = 0;
   int errors = 0;
   int ref_last;

   alu_share_arbiter #(.W(W)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_id(resp_id), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic op);
      return op ? (a >> b) : ~a;
   endfunction

   assign alu_y = alu_ref(alu_a, alu_b, alu_op);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic scramble_reqs();
      req0_valid = 1'($urandom); req0_a = W'($urandom); req0_b = W'($urandom); req0_op = 1'($urandom);
      req1_valid = 1'($urandom); req1_a = W'($urandom); req1_b = W'($urandom); req1_op = 1'($urandom);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_alu_a"}, 32'(alu_a), 0);
      chk({tag, "_alu_b"}, 32'(alu_b), 0);
      chk({tag, "_alu_op"}, 32'(alu_op), 0);
      chk({tag, "_resp_valid"}, 32'(resp_valid), 0);
      chk({tag, "_resp_data"}, 32'(resp_data), 0);
      chk({tag, "_resp_id"}, 32'(resp_id), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_r0"}, 32'(req0_ready), 0);
      chk({tag, "_r1"}, 32'(req1_ready), 0);
   endtask

   // One full transaction; called just after a rising edge with the DUT in IDLE.
   task automatic txn(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0, input logic op0,
                      input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1, input logic op1,
                      input int stall);
      int           win;
      logic [W-1:0] ea, eb, ey;
      logic         eop;
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
      resp_ready = 1'b0;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_resp_valid", 32'(resp_valid), 0);
      chk("idle_alu_a", 32'(alu_a), 0);
      if (!v0 && !v1) begin
         chk("none_r0", 32'(req0_ready), 0);
         chk("none_r1", 32'(req1_ready), 0);
         @(posedge clk); #1;
         return;
      end
      win = (v0 && v1) ? 1 - ref_last : (v0 ? 0 : 1);
      chk("grant_r0", 32'(req0_ready), 32'(win == 0));
      chk("grant_r1", 32'(req1_ready), 32'(win == 1));
      ea  = win ? a1 : a0;
      eb  = win ? b1 : b0;
      eop = win ? op1 : op0;
      ey  = alu_ref(ea, eb, eop);
      @(posedge clk); #1;
      ref_last = win;
      scramble_reqs();
      @(negedge clk);
      chk("issue_busy", 32'(busy), 1);
      chk("issue_alu_a", 32'(alu_a), 32'(ea));
      chk("issue_alu_b", 32'(alu_b), 32'(eb));
      chk("issue_alu_op", 32'(alu_op), 32'(eop));
      chk("issue_resp_valid", 32'(resp_valid), 0);
      chk("issue_r0", 32'(req0_ready), 0);
      chk("issue_r1", 32'(req1_ready), 0);
      @(posedge clk); #1;
      for (int i = 0; i <= stall; i++) begin
         if (i == stall) resp_ready = 1'b1;
         else scramble_reqs();
         @(negedge clk);
         chk("resp_valid", 32'(resp_valid), 1);
         chk("resp_data", 32'(resp_data), 32'(ey));
         chk("resp_id", 32'(resp_id), 32'(win));
         chk("resp_busy", 32'(busy), 1);
         chk("resp_alu_a", 32'(alu_a), 0);
         chk("resp_r0", 32'(req0_ready), 0);
         chk("resp_r1", 32'(req1_ready), 0);
         @(posedge clk); #1;
      end
      resp_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      resp_ready = 1'b0;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = 1'b0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 1'b0;
      ref_last = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk); #1;
      reset = 1'b0;

      // Both valid from reset: grants alternate starting with requester 0.
      for (int i = 0; i < 4; i++)
         txn(1'b1, W'($urandom), W'($urandom), 1'($urandom),
             1'b1, W'($urandom), W'($urandom), 1'($urandom), 0);

      txn(1'b1, 7'b1010101, 7'b0000000, 1'b0, 1'b0, '0, '0, 1'b0, 0);
      txn(1'b0, '0, '0, 1'b0, 1'b1, 7'b1100110, 7'b0000011, 1'b1, 0);
      txn(1'b1, 7'b0111000, 7'b0000010, 1'b1, 1'b1, 7'b0001111, 7'b0000001, 1'b0, 5);

      // Reset during ISSUE aborts the transaction.
      req0_valid = 1'b1; req0_a = 7'h3C; req0_b = 7'h01; req0_op = 1'b1;
      req1_valid = 1'b0;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      chk("abort_pre_busy", 32'(busy), 1);
      reset = 1'b1;
      #1;
      chk_all_zero("abort");
      @(posedge clk); #1;
      reset = 1'b0;
      ref_last = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_no_resp", 32'(resp_valid), 0);
         chk("abort_idle_busy", 32'(busy), 0);
      end
      @(posedge clk); #1;
      txn(1'b1, W'($urandom), W'($urandom), 1'($urandom),
          1'b1, W'($urandom), W'($urandom), 1'($urandom), 0);

      for (int i = 0; i < 60; i++)
         txn(1'($urandom), W'($urandom), W'($urandom), 1'($urandom),
             1'($urandom), W'($urandom), W'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
